// File: rtl/qracc_sram_seq.sv
// SRAM access sequencer: expands single-word read/write requests into the
// precharge / wordline / write-drive / sense-amp control sequence of the
// analog macro. Every macro-facing output is decoded from registered state.
module qracc_sram_seq #(
  parameter int numRows   = 128,
  parameter int numCols   = 32,
  parameter int pchCycles = 2,
  parameter int wlCycles  = 2,
  parameter int saCycles  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rq_valid_i,
  input  logic                       rq_wr_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  input  logic [numCols-1:0]         wr_mask_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic [numRows-1:0]         WL,
  output logic                       PCH,
  output logic                       WRITE,
  output logic [numCols-1:0]         WR_DATA,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
);

  localparam int AW   = $clog2(numRows);
  localparam int MAXC = (pchCycles > wlCycles)
                        ? ((pchCycles > saCycles) ? pchCycles : saCycles)
                        : ((wlCycles  > saCycles) ? wlCycles  : saCycles);
  localparam int CW   = $clog2(MAXC + 1);

  // Counter reload values: the counter runs down to zero in the last cycle
  // of each phase.
  localparam logic [CW-1:0] PCH_LAST = CW'(pchCycles - 1);
  localparam logic [CW-1:0] WL_LAST  = CW'(wlCycles - 1);
  localparam logic [CW-1:0] SA_LAST  = CW'(saCycles - 1);
  localparam logic [AW:0]   ROWS     = (AW + 1)'(numRows);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRECH = 3'd1,
    WLINE = 3'd2,
    SENSE = 3'd3,
    CAPT  = 3'd4,
    RECOV = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [numCols-1:0]   data_q, data_d;
  logic [numCols-1:0]   mask_q, mask_d;
  logic                 oor_q, oor_d;
  logic                 err_q, err_d;
  logic [numCols-1:0]   rd_data_q, rd_data_d;

  logic                 accept;
  logic                 oor_in;

  // Only the ready flag looks at rst combinationally so nothing is accepted
  // while reset is held.
  assign rq_ready_o = (state_q == IDLE) && !rst;
  assign accept     = rq_valid_i && rq_ready_o;
  assign oor_in     = {1'b0, addr_i} >= ROWS;

  // State register and request latches, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      oor_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      oor_q     <= oor_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next-state: each timed phase ends when its counter reaches zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = PRECH;
      PRECH: if (cnt_q == '0) state_d = WLINE;
      WLINE: if (cnt_q == '0) state_d = wr_q ? RECOV : SENSE;
      SENSE: if (cnt_q == '0) state_d = CAPT;
      CAPT:  state_d = IDLE;
      RECOV: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Phase counter, request latching, error flag and read capture.
  always_comb begin
    cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        PRECH:   cnt_d = PCH_LAST;
        WLINE:   cnt_d = WL_LAST;
        SENSE:   cnt_d = SA_LAST;
        default: cnt_d = '0;
      endcase
    end

    wr_d   = wr_q;
    addr_d = addr_q;
    data_d = data_q;
    mask_d = mask_q;
    oor_d  = oor_q;
    if (accept) begin
      wr_d   = rq_wr_i;
      addr_d = addr_i;
      data_d = wr_data_i;
      mask_d = wr_mask_i;
      oor_d  = oor_in;
    end

    // err_q is high exactly during the first PRECH cycle of a bad request.
    err_d = accept && oor_in;

    // Sense-amp data is taken at the edge that closes the last SENSE cycle.
    rd_data_d = rd_data_q;
    if ((state_q == SENSE) && (cnt_q == '0)) begin
      rd_data_d = oor_q ? '0 : SA_OUT;
    end
  end

  // Macro controls decoded from the current phase and latched request.
  always_comb begin
    WL      = '0;
    PCH     = 1'b0;
    WRITE   = 1'b0;
    WR_DATA = '0;
    CSEL    = '0;
    SAEN    = 1'b0;
    case (state_q)
      PRECH: PCH = 1'b1;
      WLINE: begin
        // An out-of-range row never matches, leaving WL all zero.
        for (int r = 0; r < numRows; r++) begin
          WL[r] = ({1'b0, addr_q} == (AW + 1)'(r));
        end
        if (wr_q) begin
          WRITE   = !oor_q && (mask_q != '0);
          WR_DATA = data_q;
          CSEL    = mask_q;
        end else begin
          CSEL = '1;
        end
      end
      SENSE: begin
        SAEN = 1'b1;
        CSEL = '1;
      end
      default: ;
    endcase
  end

  assign rd_valid_o = (state_q == CAPT);
  assign rd_data_o  = rd_data_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_qracc_sram_seq.sv
// Bench for qracc_sram_seq: two instances with different phase lengths,
// random requests, and a time-based reference model of the control sequence.
module tb_qracc_sram_seq;

  localparam int NR = 100;
  localparam int PA[2] = '{2, 1};
  localparam int WA[2] = '{2, 3};
  localparam int SA[2] = '{1, 2};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rq_valid[2], rq_wr[2];
  logic [6:0]  addr[2];
  logic [31:0] wdata[2], wmask[2], sa_out[2];
  logic        rdy[2], rdv[2], err[2], busy[2], pch[2], write[2], saen[2];
  logic [31:0] rdd[2], wrd[2], csel[2];
  logic [99:0] wl[2];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: per instance, whether a request is in flight and how
  // many cycles have elapsed since it was accepted.
  bit          m_act[2], m_wr[2], m_oor[2];
  logic [6:0]  m_addr[2];
  logic [31:0] m_data[2], m_mask[2], m_rd[2];
  int          m_e[2], m_len[2];
  logic [31:0] mem[2][128];
  int          acc_t[$];

  qracc_sram_seq #(.numRows(NR), .numCols(32), .pchCycles(2), .wlCycles(2), .saCycles(1)) u_dut0 (
    .clk(clk), .rst(rst), .rq_valid_i(rq_valid[0]), .rq_wr_i(rq_wr[0]), .addr_i(addr[0]),
    .wr_data_i(wdata[0]), .wr_mask_i(wmask[0]), .rq_ready_o(rdy[0]), .rd_valid_o(rdv[0]),
    .rd_data_o(rdd[0]), .err_o(err[0]), .busy_o(busy[0]), .WL(wl[0]), .PCH(pch[0]),
    .WRITE(write[0]), .WR_DATA(wrd[0]), .CSEL(csel[0]), .SAEN(saen[0]), .SA_OUT(sa_out[0]));

  qracc_sram_seq #(.numRows(NR), .numCols(32), .pchCycles(1), .wlCycles(3), .saCycles(2)) u_dut1 (
    .clk(clk), .rst(rst), .rq_valid_i(rq_valid[1]), .rq_wr_i(rq_wr[1]), .addr_i(addr[1]),
    .wr_data_i(wdata[1]), .wr_mask_i(wmask[1]), .rq_ready_o(rdy[1]), .rd_valid_o(rdv[1]),
    .rd_data_o(rdd[1]), .err_o(err[1]), .busy_o(busy[1]), .WL(wl[1]), .PCH(pch[1]),
    .WRITE(write[1]), .WR_DATA(wrd[1]), .CSEL(csel[1]), .SAEN(saen[1]), .SA_OUT(sa_out[1]));

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Model update: acceptance, elapsed-time tracking, read capture.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; m_e[i] = 0; m_rd[i] = '0; m_oor[i] = 1'b0; m_wr[i] = 1'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (m_act[i]) begin
          if (!m_wr[i] && m_e[i] == PA[i] + WA[i] + SA[i] - 1)
            m_rd[i] = m_oor[i] ? 32'h0 : sa_out[i];
          m_e[i]++;
          if (m_e[i] == m_len[i]) m_act[i] = 1'b0;
        end else if (rq_valid[i]) begin
          m_act[i]  = 1'b1;
          m_e[i]    = 0;
          m_wr[i]   = rq_wr[i];
          m_addr[i] = addr[i];
          m_data[i] = wdata[i];
          m_mask[i] = wmask[i];
          m_oor[i]  = (int'(addr[i]) >= NR);
          m_len[i]  = rq_wr[i] ? PA[i] + WA[i] + 1 : PA[i] + WA[i] + SA[i] + 1;
          if (rq_wr[i] && !m_oor[i])
            mem[i][addr[i]] = (mem[i][addr[i]] & ~wmask[i]) | (wdata[i] & wmask[i]);
          if (i == 1) acc_t.push_back(cyc);
        end
      end
    end
  end

  // Per-cycle output check, then drive the sense-amp outputs: the stored
  // word during the last sense cycle, noise otherwise.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int e;
      bit a, pr, wn, se, ca;
      logic [99:0] one, ewl;
      logic [31:0] ecs;
      e  = m_e[i];
      a  = m_act[i];
      pr = a && e < PA[i];
      wn = a && e >= PA[i] && e < PA[i] + WA[i];
      se = a && !m_wr[i] && e >= PA[i] + WA[i] && e < PA[i] + WA[i] + SA[i];
      ca = a && !m_wr[i] && e == PA[i] + WA[i] + SA[i];
      one = 100'd1;
      ewl = (wn && !m_oor[i]) ? (one << m_addr[i]) : 100'd0;
      ecs = wn ? (m_wr[i] ? m_mask[i] : 32'hFFFF_FFFF) : (se ? 32'hFFFF_FFFF : 32'h0);
      chk($sformatf("u%0d.ready", i), rdy[i], !a && !rst);
      chk($sformatf("u%0d.busy", i), busy[i], a);
      chk($sformatf("u%0d.PCH", i), pch[i], pr);
      chk($sformatf("u%0d.WL", i), wl[i], ewl);
      chk($sformatf("u%0d.WRITE", i), write[i], wn && m_wr[i] && !m_oor[i] && (m_mask[i] != 0));
      chk($sformatf("u%0d.WR_DATA", i), wrd[i], (wn && m_wr[i]) ? m_data[i] : 32'h0);
      chk($sformatf("u%0d.CSEL", i), csel[i], ecs);
      chk($sformatf("u%0d.SAEN", i), saen[i], se);
      chk($sformatf("u%0d.rd_valid", i), rdv[i], ca);
      chk($sformatf("u%0d.rd_data", i), rdd[i], m_rd[i]);
      chk($sformatf("u%0d.err", i), err[i], a && e == 0 && m_oor[i]);
      if (a && !m_wr[i] && e == PA[i] + WA[i] + SA[i] - 1) sa_out[i] = mem[i][m_addr[i]];
      else sa_out[i] = $urandom;
    end
  end

  // One request: wait for ready, hand it over, then measure occupancy,
  // read latency and error pulses until the instance is idle again.
  task automatic do_req(input int i, input bit wr, input logic [6:0] a,
                        input logic [31:0] d, input logic [31:0] m);
    int k, busy_n, lat, errs;
    bit done;
    step();
    rq_wr[i] = wr; addr[i] = a; wdata[i] = d; wmask[i] = m; rq_valid[i] = 1'b1;
    k = 0;
    while (!rdy[i] && k < 20) begin step(); k++; end
    if (!rdy[i]) begin
      chk($sformatf("u%0d.acc_timeout", i), 1'b0, 1'b1);
      rq_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 rq_valid[i] = 1'b0;
    busy_n = 0; lat = 0; errs = 0; done = 1'b0;
    for (k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (busy[i]) busy_n++; else done = 1'b1;
      if (rdv[i] && lat == 0) lat = k;
      if (err[i]) errs++;
    end
    chk($sformatf("u%0d.done", i), done, 1'b1);
    chk($sformatf("u%0d.occupancy", i), busy_n, wr ? PA[i] + WA[i] + 1 : PA[i] + WA[i] + SA[i] + 1);
    if (!wr) chk($sformatf("u%0d.latency", i), lat, PA[i] + WA[i] + SA[i] + 1);
    chk($sformatf("u%0d.err_pulses", i), errs, (int'(a) >= NR) ? 1 : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen;
    logic [31:0] mk;
    for (int i = 0; i < 2; i++) begin
      rq_valid[i] = 1'b0; rq_wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wmask[i] = '0;
      sa_out[i] = '0;
      for (int r = 0; r < 128; r++) mem[i][r] = '0;
    end
    rst = 1'b1;

    // Reset held with valid requests presented: nothing may start.
    rq_valid[0] = 1'b1; rq_valid[1] = 1'b1;
    repeat (4) step();
    chk("rst_ready0", rdy[0], 1'b0);
    chk("rst_ready1", rdy[1], 1'b0);
    chk("rst_busy0", busy[0], 1'b0);
    step();
    rq_valid[0] = 1'b0; rq_valid[1] = 1'b0; rst = 1'b0;
    #1;
    chk("rel_ready0", rdy[0], 1'b1);
    chk("rel_ready1", rdy[1], 1'b1);
    repeat (2) step();

    // Directed: full-mask write then read back; masked writes; out of range.
    do_req(0, 1'b1, 7'd5, 32'hA5A5_0F0F, 32'hFFFF_FFFF);
    do_req(0, 1'b0, 7'd5, 32'h0, 32'h0);
    chk("rd5_data", rdd[0], 32'hA5A5_0F0F);
    do_req(0, 1'b1, 7'd7, 32'h1234_5678, 32'h0000_00FF);
    do_req(0, 1'b0, 7'd7, 32'h0, 32'h0);
    chk("rd7_data", rdd[0], 32'h0000_0078);
    do_req(0, 1'b1, 7'd9, 32'hDEAD_BEEF, 32'h0);
    do_req(0, 1'b0, 7'd110, 32'h0, 32'h0);
    chk("oor_rd_data", rdd[0], 32'h0);
    do_req(0, 1'b1, 7'd110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_req(1, 1'b1, 7'd99, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    do_req(1, 1'b0, 7'd99, 32'h0, 32'h0);
    chk("rd99_data", rdd[1], 32'hCAFE_F00D);

    // Random traffic on both instances.
    for (int j = 0; j < 24; j++) begin
      k = $urandom % 4;
      mk = (k == 0) ? 32'h0 : (k == 1) ? 32'hFFFF_FFFF : 32'($urandom);
      do_req(j % 2, 1'($urandom % 2), 7'($urandom_range(0, 127)), 32'($urandom), mk);
    end

    // Back-to-back reads held valid on the swept instance.
    step();
    acc_t.delete();
    rq_wr[1] = 1'b0; addr[1] = 7'd3; rq_valid[1] = 1'b1;
    repeat (48) step();
    rq_valid[1] = 1'b0;
    k = 0;
    while (busy[1] && k < 20) begin step(); k++; end
    chk("b2b_idle", busy[1], 1'b0);
    chk("b2b_count_ok", acc_t.size() >= 5, 1'b1);
    for (int g = 1; g < acc_t.size(); g++)
      chk($sformatf("b2b_gap%0d", g), acc_t[g] - acc_t[g-1], PA[1] + WA[1] + SA[1] + 2);

    // Reset during the sense phase drops the read.
    step();
    rq_wr[0] = 1'b0; addr[0] = 7'd5; rq_valid[0] = 1'b1;
    @(posedge clk);
    #1 rq_valid[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (saen[0]) seen = 1'b1;
    end
    chk("midrd_saen_seen", seen, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrd_saen_drop", saen[0], 1'b0);
    chk("midrd_busy_drop", busy[0], 1'b0);
    chk("midrd_no_valid", rdv[0], 1'b0);
    chk("midrd_rd_clear", rdd[0], 32'h0);
    step();
    rst = 1'b0;
    repeat (10) step();
    do_req(0, 1'b0, 7'd5, 32'h0, 32'h0);
    chk("post_rst_rd5", rdd[0], mem[0][5]);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qracc_sram_seq.md
# qracc_sram_seq

Parametrised SRAM access sequencer for the QR accelerator macro. It accepts single-word read/write requests on the digital SRAM handshake and expands each one into the timed analog control sequence: precharge, wordline, write drive or sense-amp enable. The phase lengths are configurable. Writes carry a per-column write mask. Out-of-range addresses are detected. The block sits between the digital controller (SRAM master) and the SRAM-related fields of the analog macro control bundle.

## Interface
- numRows, 128: wordlines; any value ≥2, not required to be a power of two
- numCols, 32: bitlines/columns per word
- pchCycles, 2: precharge phase length in cycles, ≥1
- wlCycles, 2: wordline phase length in cycles, ≥1
- saCycles, 1: sense phase length in cycles, ≥1
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rq_valid_i  in  1  request valid
- rq_wr_i  in  1  1 = write, 0 = read
- addr_i  in  $clog2(numRows)  row address
- wr_data_i  in  numCols  write data
- wr_mask_i  in  numCols  per-column write enable; 1 = column written
- rq_ready_o  out  1  request accepted on a cycle where rq_valid_i && rq_ready_o
- rd_valid_o  out  1  one-cycle pulse; rd_data_o is valid in this cycle
- rd_data_o  out  numCols  read data; holds its value until the next read capture
- err_o  out  1  one-cycle pulse: accepted request had addr_i ≥ numRows
- busy_o  out  1  high in every state except IDLE
- WL  out  numRows  one-hot wordline
- PCH  out  1  precharge enable, active-high
- WRITE  out  1  write-driver enable
- WR_DATA  out  numCols  write driver data
- CSEL  out  numCols  column select
- SAEN  out  1  sense-amp enable
- SA_OUT  in  numCols  sense-amp outputs from the macro

## Operation
- States: IDLE, PRECH, WLINE, SENSE, CAPT, RECOV.
- All outputs are registered/state-decoded; there are no combinational input-to-output paths except rq_ready_o = (state==IDLE) && !rst.
- IDLE: rq_ready_o=1.
  - On handshake, latch wr, addr, data and mask, then go to PRECH.
  - Requests presented while not ready are ignored; the master must hold them.
- PRECH: PCH=1 for pchCycles, then go to WLINE.
- WLINE: WL = onehot(addr) for wlCycles.
  - Write: WRITE=1 only if the latched mask ≠0. WR_DATA = latched data. CSEL = latched mask.
  - Read: WRITE=0, CSEL = all ones.
  - Exit: write → RECOV, read → SENSE.
- SENSE: WL=0, SAEN=1, CSEL = all ones for saCycles, then go to CAPT.
- CAPT (1 cycle):
  - rd_data_o ← SA_OUT sampled at the last SENSE edge; zero if the address was out of range.
  - rd_valid_o=1, then go to IDLE.
- RECOV (1 cycle): all analog controls 0, then go to IDLE.
- Out of range (addr ≥ numRows):
  - The full sequence still runs with WL all zero and WRITE=0.
  - err_o pulses in the first PRECH cycle.
- A phase counter, $clog2(max(pchCycles,wlCycles,saCycles)+1) bits wide, reloads on every state change.
- Outside their own phase, WL, PCH, WRITE, SAEN are 0, and WR_DATA and CSEL are 0.
- Reset (async, any state):
  - State goes to IDLE; counter, latches and rd_data_o clear to 0.
  - All analog outputs, rd_valid_o, err_o and busy_o go to 0 immediately.
  - An in-flight request is dropped and produces no rd_valid_o.

## Timing
- Acceptance at edge T (request seen in cycle T-1, while in IDLE).
- Read:
  - PCH high for pchCycles cycles starting at T.
  - rd_valid_o is high for the cycle after edge T+pchCycles+wlCycles+saCycles.
  - Read latency L_rd = pchCycles+wlCycles+saCycles+1 cycles from acceptance (defaults: 6).
- Write occupancy: pchCycles+wlCycles+1 cycles (defaults: 5).
- rq_ready_o returns high in the cycle after CAPT/RECOV, so back-to-back throughput is one request per L+1 cycles.
- rq_ready_o is 0 while rst=1. It is 1 in the first cycle after rst falls.

## Test plan
- Reset: hold rst, drive rq_valid_i=1 → all outputs 0 and rq_ready_o=0. Release → rq_ready_o=1 in the next cycle with no spurious pulses.
- Write then read:
  - Write addr=5, data=0xA5A5_0F0F, mask=all ones (defaults) → PCH for 2 cycles, WL[5] for 2 cycles with WRITE=1 and CSEL=0xFFFF_FFFF.
  - Read addr=5 with model SA_OUT=0xA5A5_0F0F → rd_valid_o exactly 6 cycles after acceptance, rd_data_o=0xA5A5_0F0F.
- Masked writes:
  - mask=0x0000_00FF → CSEL=0x0000_00FF and WRITE=1.
  - mask=0 → WRITE stays 0 through WLINE, and busy_o lasts 5 cycles.
- Out of range: numRows=100, read addr=110 → err_o pulses once, WL stays 0, rd_valid_o pulses with rd_data_o=0.
- Parameter sweep: pchCycles=1, wlCycles=3, saCycles=2 → read latency 7, phase widths exact. Back-to-back valid → accepts spaced 8 cycles apart.
- Reset mid-read: assert rst during SENSE → SAEN drops asynchronously, no rd_valid_o pulse, and the next read completes normally.
